icache_mo_interface: RTL and testbench
======================================

# icache_mo_interface

Fetch-side bridge between the IF stage and the instruction cache. It allows up to DEPTH reads to be in flight to the cache at once, with responses returned in order. It returns each instruction word together with the PC it was fetched from. On a pipeline flush it silently discards responses to requests issued before the flush, so the fetch unit never sees stale data.

## Interface
- XLEN, 32, address width
- DATA_W, 32, width of a cache response word
- DEPTH, 4, maximum outstanding cache reads; power of two, ≥2
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  pipeline flush, synchronous, single-cycle pulse
- pc_i  in  XLEN  fetch address from IF
- read_req_i  in  1  IF read request
- read_ready_o  out  1  request accepted this cycle when high together with read_req_i
- data_o  out  DATA_W  returned instruction word
- pc_o  out  XLEN  PC belonging to data_o
- read_done_o  out  1  data_o/pc_o valid this cycle
- addr_o  out  XLEN  address to icache
- addr_valid_o  out  1  address valid to icache
- addr_ready_i  in  1  icache accepts address
- data_i  in  DATA_W  icache response word
- data_valid_i  in  1  icache response valid
- data_ready_o  out  1  interface accepts response
- outstanding_o  out  $clog2(DEPTH+1)  reads currently in flight, including reads marked for drop

## Operation
- Credit: credit = (outstanding < DEPTH).
- Request register: req_vld_q, req_pc_q. It holds a request that IF handed over but the cache has not yet accepted.
- read_ready_o = ~req_vld_q & credit & ~flush_i.
- addr_valid_o = ~flush_i & credit & (req_vld_q | read_req_i).
- addr_o = req_vld_q ? req_pc_q : pc_i.
- Request accept (read_req_i & read_ready_o) with addr_ready_i low: load req_pc_q ← pc_i and set req_vld_q. IF may then deassert read_req_i.
- Address handshake (addr_valid_o & addr_ready_i):
  - push addr_o into the PC FIFO (DEPTH entries);
  - clear req_vld_q;
  - outstanding +1.
- data_ready_o = (outstanding != 0).
- Response handshake (data_valid_i & data_ready_o):
  - pop the PC FIFO;
  - outstanding −1.
- Handling of a popped response:
  - If drop_cnt != 0: drop_cnt −1 and read_done_o = 0 (response discarded).
  - Otherwise, if flush_i is low: read_done_o = 1, data_o = data_i, pc_o = FIFO head.
- Simultaneous push and pop in one cycle leave outstanding unchanged. The FIFO pointers wrap modulo DEPTH.
- Flush (flush_i = 1):
  - req_vld_q ← 0;
  - no address handshake this cycle;
  - read_done_o = 0;
  - drop_cnt ← outstanding after this cycle's pop. Every in-flight read is then marked stale, including a response that arrives in the flush cycle (it is consumed and discarded).
- A second flush while drops are pending recomputes drop_cnt the same way. The value never exceeds outstanding.
- data_valid_i while outstanding = 0 is a protocol violation. It is ignored (data_ready_o = 0) and has no state change.

## Timing
- Reset values:
  - state: req_vld_q = 0, outstanding = 0, drop_cnt = 0, FIFO pointers = 0;
  - outputs: read_ready_o = 1, addr_valid_o = 0, data_ready_o = 0, read_done_o = 0, outstanding_o = 0, addr_o = pc_i, data_o = data_i, pc_o = FIFO entry 0.
- Reset is asynchronous. Asserting it mid-operation discards all in-flight state immediately. Responses arriving after reset release with outstanding = 0 are ignored.
- Address path is combinational: a request with addr_ready_i high reaches the cache in the same cycle (0-cycle latency).
- Response path is combinational: read_done_o follows data_valid_i in the same cycle.
- Throughput is one request and one response per cycle, sustained.
- Credit is computed from registered outstanding. With outstanding = DEPTH, a same-cycle pop does not free a slot until the next cycle.
- Full: outstanding = DEPTH → read_ready_o = 0 and addr_valid_o = 0.
- Empty: outstanding = 0 → data_ready_o = 0.

## Test plan
- Back-to-back fetch:
  - Stimulus: DEPTH = 4, addr_ready_i = 1. Requests at PC 0x100, 0x104, 0x108, 0x10C on consecutive cycles. Responses D0..D3 return 3 cycles later, one per cycle.
  - Required: read_done_o asserted 4 cycles in a row with pc_o = 0x100..0x10C in order. outstanding_o peaks at 3.
- Full stall:
  - Stimulus: issue 4 requests with no responses.
  - Required: 5th request sees read_ready_o = 0 and addr_valid_o = 0. After one response, the 5th is accepted the next cycle.
- Cache busy:
  - Stimulus: request at 0x200 with addr_ready_i = 0, read_req_i dropped next cycle, addr_ready_i = 1 two cycles later.
  - Required: addr_valid_o stays high with addr_o = 0x200 until the handshake. Response returns pc_o = 0x200.
- Flush with in-flight reads:
  - Stimulus: 3 outstanding reads, then flush_i pulse, then request at 0x400, then 4 responses.
  - Required: the first 3 responses produce read_done_o = 0. The 4th gives read_done_o = 1 and pc_o = 0x400.
- Flush coincident with a response:
  - Stimulus: 2 outstanding reads; flush_i in the same cycle as the first response.
  - Required: read_done_o = 0 that cycle; drop_cnt = 1; the second response is discarded; outstanding_o = 0 afterward.
- Async reset mid-operation:
  - Stimulus: rst_n_i low with 3 outstanding reads and req_vld_q set.
  - Required: all outputs at reset values immediately. A response arriving after release is not acknowledged (data_ready_o = 0).

Source files
------------

// File: rtl/icache_mo_interface.sv
// Fetch-side bridge to the instruction cache: up to DEPTH in-order reads in flight,
// each response tagged with its PC, stale responses dropped after a pipeline flush.
module icache_mo_interface #(
  parameter int XLEN   = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic                       read_req_i,
  output logic                       read_ready_o,
  output logic [DATA_W-1:0]          data_o,
  output logic [XLEN-1:0]            pc_o,
  output logic                       read_done_o,
  output logic [XLEN-1:0]            addr_o,
  output logic                       addr_valid_o,
  input  logic                       addr_ready_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       data_valid_i,
  output logic                       data_ready_o,
  output logic [$clog2(DEPTH+1)-1:0] outstanding_o
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic            req_vld_q, req_vld_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] pc_fifo_q [DEPTH];

  logic credit, accept, push, pop;

  always_comb begin
    credit        = (outstanding_q < OW'(DEPTH));
    read_ready_o  = ~req_vld_q & credit & ~flush_i;
    addr_valid_o  = ~flush_i & credit & (req_vld_q | read_req_i);
    addr_o        = req_vld_q ? req_pc_q : pc_i;
    accept        = read_req_i & read_ready_o;
    push          = addr_valid_o & addr_ready_i;
    data_ready_o  = (outstanding_q != '0);
    pop           = data_valid_i & data_ready_o;
    read_done_o   = pop & (drop_cnt_q == '0) & ~flush_i;
    data_o        = data_i;
    pc_o          = pc_fifo_q[rd_ptr_q];
    outstanding_o = outstanding_q;
  end

  always_comb begin
    req_vld_d     = req_vld_q;
    req_pc_d      = req_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + OW'(push) - OW'(pop);

    if (accept && !addr_ready_i) begin
      req_vld_d = 1'b1;
      req_pc_d  = pc_i;
    end
    if (push) begin
      req_vld_d = 1'b0;
      wr_ptr_d  = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - OW'(1);
    end
    // No push can happen during a flush, so every read still in flight after the pop is stale.
    if (flush_i) begin
      req_vld_d  = 1'b0;
      drop_cnt_d = outstanding_q - OW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_vld_q     <= 1'b0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      req_vld_q     <= req_vld_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Address storage carries no control meaning on its own, so it is left unreset.
  always_ff @(posedge clk_i) begin
    req_pc_q <= req_pc_d;
    if (push) pc_fifo_q[wr_ptr_q] <= addr_o;
  end

endmodule

// File: tb/tb_icache_mo_interface.sv
// Bench for icache_mo_interface: directed scenarios with literal expectations, then
// random traffic compared every cycle against a queue-based model of in-flight reads.
module tb_icache_mo_interface;

  localparam int XLEN   = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int OW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [XLEN-1:0]   pc_in = '0;
  logic              req = 1'b0;
  logic              read_ready;
  logic [DATA_W-1:0] data_out;
  logic [XLEN-1:0]   pc_out;
  logic              read_done;
  logic [XLEN-1:0]   addr;
  logic              addr_valid;
  logic              addr_ready = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              data_valid = 1'b0;
  logic              data_ready;
  logic [OW-1:0]     outstanding;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [XLEN-1:0] mq[$];
  int              m_drop = 0;
  bit              m_pend = 1'b0;
  logic [XLEN-1:0] m_ppc = '0;

  icache_mo_interface #(.XLEN(XLEN), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .flush_i       (flush),
    .pc_i          (pc_in),
    .read_req_i    (req),
    .read_ready_o  (read_ready),
    .data_o        (data_out),
    .pc_o          (pc_out),
    .read_done_o   (read_done),
    .addr_o        (addr),
    .addr_valid_o  (addr_valid),
    .addr_ready_i  (addr_ready),
    .data_i        (data_in),
    .data_valid_i  (data_valid),
    .data_ready_o  (data_ready),
    .outstanding_o (outstanding)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a queue of PCs in flight, a pending-request slot and a count of stale responses.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_drop = 0;
      m_pend = 1'b0;
      chk("rst_read_ready", 64'(read_ready), 64'(!flush));
      chk("rst_data_ready", 64'(data_ready), 64'd0);
      chk("rst_read_done",  64'(read_done),  64'd0);
      chk("rst_outstanding", 64'(outstanding), 64'd0);
    end else begin
      bit credit, e_rr, e_av, e_dr, e_pop, e_done, e_push;
      logic [XLEN-1:0] e_addr;
      credit = mq.size() < DEPTH;
      e_rr   = !m_pend && credit && !flush;
      e_av   = !flush && credit && (m_pend || req);
      e_addr = m_pend ? m_ppc : pc_in;
      e_dr   = mq.size() != 0;
      e_pop  = data_valid && e_dr;
      e_done = e_pop && (m_drop == 0) && !flush;
      e_push = e_av && addr_ready;
      chk("m_read_ready",  64'(read_ready),  64'(e_rr));
      chk("m_addr_valid",  64'(addr_valid),  64'(e_av));
      if (e_av) chk("m_addr", 64'(addr), 64'(e_addr));
      chk("m_data_ready",  64'(data_ready),  64'(e_dr));
      chk("m_read_done",   64'(read_done),   64'(e_done));
      chk("m_outstanding", 64'(outstanding), 64'(mq.size()));
      if (e_done) begin
        chk("m_pc_o",   64'(pc_out),   64'(mq[0]));
        chk("m_data_o", 64'(data_out), 64'(data_in));
      end
      if (e_pop) begin
        void'(mq.pop_front());
        if (m_drop > 0) m_drop--;
      end
      if (e_push) begin
        mq.push_back(e_addr);
        m_pend = 1'b0;
      end else if (req && e_rr) begin
        m_pend = 1'b1;
        m_ppc  = pc_in;
      end
      if (flush) begin
        m_pend = 1'b0;
        m_drop = mq.size();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic r, input logic [XLEN-1:0] p, input logic ar,
                     input logic dv, input logic [DATA_W-1:0] d, input logic fl);
    req = r; pc_in = p; addr_ready = ar; data_valid = dv; data_in = d; flush = fl;
  endtask

  initial begin
    set(0, 32'h0, 0, 0, 32'h0, 0);
    #1;
    chk("reset_read_ready", 64'(read_ready), 64'd1);
    chk("reset_addr_valid", 64'(addr_valid), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Back-to-back fetch
    set(1, 32'h100, 1, 0, 0, 0); #1; chk("b2b_out0", 64'(outstanding), 64'd0); tick();
    set(1, 32'h104, 1, 0, 0, 0); tick();
    set(1, 32'h108, 1, 0, 0, 0); tick();
    set(1, 32'h10C, 1, 1, 32'hD0, 0); #1;
    chk("b2b_out_peak", 64'(outstanding), 64'd3);
    chk("b2b_done0", 64'(read_done), 64'd1); chk("b2b_pc0", 64'(pc_out), 64'h100); tick();
    for (int i = 1; i < 4; i++) begin
      set(0, 32'h0, 0, 1, 32'hD0 + 32'(i), 0); #1;
      chk("b2b_done", 64'(read_done), 64'd1);
      chk("b2b_pc", 64'(pc_out), 64'(32'h100 + 32'(4 * i)));
      chk("b2b_out", 64'(outstanding), 64'(4 - i));
      tick();
    end
    set(0, 32'h0, 0, 0, 0, 0); #1; chk("b2b_empty", 64'(outstanding), 64'd0); tick();

    // Full stall
    for (int i = 0; i < 4; i++) begin set(1, 32'h500 + 32'(4 * i), 1, 0, 0, 0); tick(); end
    set(1, 32'h510, 1, 0, 0, 0); #1;
    chk("full_rr", 64'(read_ready), 64'd0); chk("full_av", 64'(addr_valid), 64'd0);
    chk("full_out", 64'(outstanding), 64'd4); tick();
    set(1, 32'h510, 1, 1, 32'hE0, 0); #1;
    chk("full_pop_rr", 64'(read_ready), 64'd0); chk("full_pop_done", 64'(read_done), 64'd1); tick();
    set(1, 32'h510, 1, 0, 0, 0); #1;
    chk("full_free_rr", 64'(read_ready), 64'd1); chk("full_free_av", 64'(addr_valid), 64'd1); tick();
    for (int i = 0; i < 4; i++) begin set(0, 0, 0, 1, 32'hE1 + 32'(i), 0); tick(); end
    set(0, 0, 0, 0, 0, 0); tick();

    // Cache busy
    set(1, 32'h200, 0, 0, 0, 0); #1; chk("busy_rr", 64'(read_ready), 64'd1); tick();
    for (int i = 0; i < 2; i++) begin
      set(0, 32'h999, 0, 0, 0, 0); #1;
      chk("busy_av", 64'(addr_valid), 64'd1); chk("busy_addr", 64'(addr), 64'h200);
      chk("busy_rr_hold", 64'(read_ready), 64'd0); tick();
    end
    set(0, 32'h999, 1, 0, 0, 0); #1;
    chk("busy_hs_av", 64'(addr_valid), 64'd1); chk("busy_hs_addr", 64'(addr), 64'h200); tick();
    set(0, 0, 0, 1, 32'hF0, 0); #1;
    chk("busy_done", 64'(read_done), 64'd1); chk("busy_pc", 64'(pc_out), 64'h200); tick();
    set(0, 0, 0, 0, 0, 0); tick();

    // Flush with in-flight reads
    for (int i = 0; i < 3; i++) begin set(1, 32'h300 + 32'(4 * i), 1, 0, 0, 0); tick(); end
    set(1, 32'h30C, 1, 0, 0, 1); #1;
    chk("fl_av", 64'(addr_valid), 64'd0); chk("fl_rr", 64'(read_ready), 64'd0); tick();
    set(1, 32'h400, 1, 0, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      set(0, 0, 0, 1, 32'hA0 + 32'(i), 0); #1;
      chk("fl_done", 64'(read_done), 64'(i == 3));
      if (i == 3) chk("fl_pc", 64'(pc_out), 64'h400);
      tick();
    end
    set(0, 0, 0, 0, 0, 0); tick();

    // Flush coincident with a response
    for (int i = 0; i < 2; i++) begin set(1, 32'h700 + 32'(4 * i), 1, 0, 0, 0); tick(); end
    set(0, 0, 0, 1, 32'hB0, 1); #1; chk("flc_done0", 64'(read_done), 64'd0); tick();
    set(0, 0, 0, 1, 32'hB1, 0); #1;
    chk("flc_done1", 64'(read_done), 64'd0); chk("flc_dr", 64'(data_ready), 64'd1); tick();
    set(0, 0, 0, 0, 0, 0); #1; chk("flc_out", 64'(outstanding), 64'd0); tick();

    // Async reset mid-operation
    for (int i = 0; i < 3; i++) begin set(1, 32'h600 + 32'(4 * i), 1, 0, 0, 0); tick(); end
    set(1, 32'h60C, 0, 0, 0, 0); tick();
    set(0, 32'h0, 0, 0, 0, 0); #2;
    rst_n = 1'b0; #1;
    chk("arst_out", 64'(outstanding), 64'd0); chk("arst_av", 64'(addr_valid), 64'd0);
    chk("arst_rr", 64'(read_ready), 64'd1); chk("arst_dr", 64'(data_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    set(0, 0, 0, 1, 32'hC0, 0); #1;
    chk("arst_post_dr", 64'(data_ready), 64'd0); chk("arst_post_done", 64'(read_done), 64'd0);
    tick();
    set(0, 0, 0, 0, 0, 0); #1; chk("arst_post_out", 64'(outstanding), 64'd0); tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      set($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 19) == 0);
      tick();
    end
    set(0, 0, 0, 0, 0, 0); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
